// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface: request side from the agents, grant side from
// the arbiter.
//
// Handshake: an agent raises bus_req (level) with bus_req_type/bus_req_clc
// valid and keeps it high until it sees its bit in bus_grant. The grant lasts
// while bus_active is high. The agent may drop bus_req during its tenure to
// release the bus early; the arbiter honours the drop on the next edge.
// Dropping bus_req before a grant simply withdraws the request.
interface bus_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int CLC_WIDTH = 6,
   parameter int ID_WIDTH  = 2
);
   logic [NUM_REQ-1:0]           bus_req;
   logic [NUM_REQ-1:0]           bus_req_type;
   logic [NUM_REQ*CLC_WIDTH-1:0] bus_req_clc;
   logic [NUM_REQ-1:0]           bus_grant;
   logic                         bus_active;
   logic [ID_WIDTH-1:0]          grant_id;
   logic [CLC_WIDTH-1:0]         tenure_left;

   // Agent side: drives requests, observes grants.
   modport master (
      output bus_req, bus_req_type, bus_req_clc,
      input  bus_grant, bus_active, grant_id, tenure_left
   );

   // Arbiter side: observes requests, drives grants.
   modport slave (
      input  bus_req, bus_req_type, bus_req_clc,
      output bus_grant, bus_active, grant_id, tenure_left
   );
endinterface

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared system bus. Picks one owner at a time with
// type-1 priority, round-robin fairness and a starvation guard for type-0
// requests, and inserts one turnaround cycle between tenures.
module bus_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int CLC_WIDTH    = 6,
   parameter int STARVE_LIMIT = 4,
   parameter int ID_WIDTH     = 2
) (
   input  logic         plusclk,
   input  logic         rst,
   bus_arbiter_if.slave bus,
   output logic [1:0]   state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   localparam int                  SW       = $clog2(STARVE_LIMIT + 1);
   localparam int                  IW1      = ID_WIDTH + 1;
   localparam logic [SW-1:0]       STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [IW1-1:0]      NUM_W    = IW1'(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

   state_t              state;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [SW-1:0]       starve_cnt;

   logic [NUM_REQ-1:0]   type1_v;
   logic [NUM_REQ-1:0]   type0_v;
   logic [NUM_REQ-1:0]   cand;
   logic [2*NUM_REQ-1:0] cand_sh;
   logic [NUM_REQ-1:0]   rot;
   logic                 pend0;
   logic                 have_win;
   logic [ID_WIDTH-1:0]  rot_idx;
   logic [IW1-1:0]       win_sum;
   logic [ID_WIDTH-1:0]  win_id;
   logic [NUM_REQ-1:0]   win_oh;
   logic                 win_is_t1;
   logic [CLC_WIDTH-1:0] clc_arr [NUM_REQ];
   logic [CLC_WIDTH-1:0] win_clc;
   logic                 tenure_end;

   assign state_dbg = state;

   // Per-requester tenure length fields unpacked for indexing by winner id.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         clc_arr[k] = bus.bus_req_clc[k*CLC_WIDTH +: CLC_WIDTH];
      end
   end

   // Candidate set and round-robin winner search starting at rr_ptr.
   always_comb begin
      type1_v = bus.bus_req & bus.bus_req_type;
      type0_v = bus.bus_req & ~bus.bus_req_type;
      pend0   = |type0_v;
      if ((starve_cnt == STARVE_MAX) && pend0) begin
         cand = type0_v;
      end else if (|type1_v) begin
         cand = type1_v;
      end else begin
         cand = bus.bus_req;
      end
      // Rotate so rr_ptr lands at bit 0; lowest set bit is then the winner.
      cand_sh  = {cand, cand} >> rr_ptr;
      rot      = cand_sh[NUM_REQ-1:0];
      have_win = |rot;
      rot_idx  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            rot_idx = k[ID_WIDTH-1:0];
         end
      end
      win_sum = {1'b0, rr_ptr} + {1'b0, rot_idx};
      if (win_sum >= NUM_W) begin
         win_sum = win_sum - NUM_W;
      end
      win_id    = win_sum[ID_WIDTH-1:0];
      win_oh    = NUM_REQ'(1) << win_id;
      win_is_t1 = |(type1_v & win_oh);
      win_clc   = (clc_arr[win_id] == '0) ? CLC_WIDTH'(1) : clc_arr[win_id];
   end

   // Tenure finishes on its last counted cycle or when the owner lets go.
   assign tenure_end = (bus.tenure_left == CLC_WIDTH'(1)) ||
                       !(|(bus.bus_req & bus.bus_grant));

   // Arbitration FSM with registered grant outputs.
   always_ff @(posedge plusclk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         rr_ptr          <= '0;
         starve_cnt      <= '0;
         bus.bus_grant   <= '0;
         bus.bus_active  <= 1'b0;
         bus.grant_id    <= '0;
         bus.tenure_left <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_TURN: begin
               if (have_win) begin
                  state           <= ST_OWN;
                  bus.bus_grant   <= win_oh;
                  bus.bus_active  <= 1'b1;
                  bus.grant_id    <= win_id;
                  bus.tenure_left <= win_clc;
                  rr_ptr          <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                  if (win_is_t1 && pend0) begin
                     if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end else begin
                     starve_cnt <= '0;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_OWN: begin
               if (tenure_end) begin
                  state           <= ST_TURN;
                  bus.bus_grant   <= '0;
                  bus.bus_active  <= 1'b0;
                  bus.tenure_left <= '0;
               end else begin
                  bus.tenure_left <= bus.tenure_left - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against an owner/countdown reference model.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int CW = 6;
   localparam int IW = 2;
   localparam int SL = 4;

   logic       plusclk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] state_dbg;

   bus_arbiter_if #(.NUM_REQ(N), .CLC_WIDTH(CW), .ID_WIDTH(IW)) bus ();

   bus_arbiter #(
      .NUM_REQ(N), .CLC_WIDTH(CW), .STARVE_LIMIT(SL), .ID_WIDTH(IW)
   ) dut (
      .plusclk  (plusclk),
      .rst      (rst),
      .bus      (bus),
      .state_dbg(state_dbg)
   );

   // Clock.
   always #5 plusclk = ~plusclk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: who owns the bus, how many cycles remain, fairness state.
   int m_owner;
   int m_left;
   int m_rr;
   int m_starve;

   logic [N-1:0]  hist [32];
   logic [CW-1:0] tl_hist [32];

   function automatic void model_reset();
      m_owner  = -1;
      m_left   = 0;
      m_rr     = 0;
      m_starve = 0;
   endfunction

   function automatic int req_clc(int i);
      return int'(bus.bus_req_clc[i*CW +: CW]);
   endfunction

   // One rising edge of the arbiter, from the arbitration rules.
   function automatic void model_edge();
      int pend0;
      int any1;
      int w;
      int idx;
      bit cand [N];
      if (m_owner >= 0) begin
         if (m_left == 1 || bus.bus_req[m_owner] == 1'b0) begin
            m_owner = -1;
            m_left  = 0;
         end else begin
            m_left = m_left - 1;
         end
      end else begin
         pend0 = 0;
         any1  = 0;
         for (int i = 0; i < N; i++) begin
            if (bus.bus_req[i] && !bus.bus_req_type[i]) pend0 = 1;
            if (bus.bus_req[i] && bus.bus_req_type[i])  any1  = 1;
         end
         for (int i = 0; i < N; i++) begin
            if (m_starve == SL && pend0 == 1)
               cand[i] = bus.bus_req[i] && !bus.bus_req_type[i];
            else if (any1 == 1)
               cand[i] = bus.bus_req[i] && bus.bus_req_type[i];
            else
               cand[i] = bus.bus_req[i];
         end
         w = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (w < 0 && cand[idx]) w = idx;
         end
         if (w >= 0) begin
            m_owner = w;
            m_left  = (req_clc(w) == 0) ? 1 : req_clc(w);
            m_rr    = (w + 1) % N;
            if (bus.bus_req_type[w] && pend0 == 1)
               m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
            else
               m_starve = 0;
         end
      end
   endfunction

   function automatic logic [12:0] exp_vec();
      logic [N-1:0] g;
      if (m_owner < 0) return 13'd0;
      g = '0;
      g[m_owner] = 1'b1;
      return {1'b1, g, IW'(m_owner), CW'(m_left)};
   endfunction

   function automatic logic [12:0] obs_vec();
      return {bus.bus_active, bus.bus_grant,
              (bus.bus_active === 1'b1) ? bus.grant_id : 2'd0, bus.tenure_left};
   endfunction

   // Driver tasks.
   task automatic drive_idle();
      bus.bus_req      = '0;
      bus.bus_req_type = '0;
      bus.bus_req_clc  = '0;
   endtask

   task automatic set_req(input int i, input bit t, input int c);
      bus.bus_req[i]               = 1'b1;
      bus.bus_req_type[i]          = t;
      bus.bus_req_clc[i*CW +: CW]  = CW'(c);
   endtask

   task automatic tick();
      @(posedge plusclk);
      model_edge();
      #2;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      drive_idle();
      model_reset();
      repeat (2) @(posedge plusclk);
      @(negedge plusclk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive_idle();
      model_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 9));
      for (int c = 0; c < 3; c++) begin
         @(posedge plusclk);
         #2;
         n_cmp++;
         if (obs_vec() !== 13'd0) begin
            n_bad++;
            $display("FAIL reset cyc %0d: got %h want 0", c, obs_vec());
         end
      end
      drive_idle();
      @(negedge plusclk);
      rst = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      set_req(1, 1'b0, 7);
      for (int c = 0; c < 12; c++) begin
         tick();
         hist[c] = bus.bus_grant;
         tl_hist[c] = bus.tenure_left;
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      for (int c = 0; c < 9; c++) begin
         n_cmp++;
         if (hist[c] !== ((c == 7) ? 4'b0000 : 4'b0010)) begin
            n_bad++;
            $display("FAIL single_grant cyc %0d: got %b want %b", c, hist[c],
                     (c == 7) ? 4'b0000 : 4'b0010);
         end
      end
      n_cmp++;
      if (tl_hist[0] !== 6'd7 || tl_hist[6] !== 6'd1) begin
         n_bad++;
         $display("FAIL single_tenure: got %0d/%0d want 7/1", tl_hist[0], tl_hist[6]);
      end
      drive_idle();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want;
      apply_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 2);
      for (int c = 0; c < 15; c++) begin
         tick();
         hist[c] = bus.bus_grant;
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rr_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      for (int c = 0; c < 15; c++) begin
         want = (c % 3 == 2) ? 4'b0000 : 4'(1 << ((c / 3) % 4));
         n_cmp++;
         if (hist[c] !== want) begin
            n_bad++;
            $display("FAIL rr_order cyc %0d: got %b want %b", c, hist[c], want);
         end
      end
      drive_idle();
   endtask

   task automatic test_priority();
      apply_reset();
      set_req(0, 1'b0, 2);
      set_req(3, 1'b1, 3);
      for (int c = 0; c < 7; c++) begin
         tick();
         hist[c] = bus.bus_grant;
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL prio_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (c == 2) bus.bus_req[3] = 1'b0;
      end
      n_cmp++;
      if (hist[0] !== 4'b1000 || hist[2] !== 4'b1000 || hist[3] !== 4'b0000 ||
          hist[4] !== 4'b0001) begin
         n_bad++;
         $display("FAIL prio_order: got %b %b %b %b want 1000 1000 0000 0001",
                  hist[0], hist[2], hist[3], hist[4]);
      end
      drive_idle();
   endtask

   task automatic test_starvation();
      int seq [10];
      seq = '{1, 2, 1, 2, 0, 1, 2, 1, 2, 0};
      apply_reset();
      set_req(0, 1'b0, 1);
      set_req(1, 1'b1, 1);
      set_req(2, 1'b1, 1);
      for (int c = 0; c < 20; c++) begin
         tick();
         hist[c] = bus.bus_grant;
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL starve_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      for (int c = 0; c < 20; c++) begin
         n_cmp++;
         if (hist[c] !== ((c % 2 == 1) ? 4'b0000 : 4'(1 << seq[c/2]))) begin
            n_bad++;
            $display("FAIL starve_order cyc %0d: got %b want %b", c, hist[c],
                     (c % 2 == 1) ? 4'b0000 : 4'(1 << seq[c/2]));
         end
      end
      drive_idle();
   endtask

   task automatic test_early_release();
      apply_reset();
      set_req(2, 1'b0, 10);
      for (int c = 0; c < 8; c++) begin
         tick();
         hist[c] = bus.bus_grant;
         tl_hist[c] = bus.tenure_left;
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL early_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
         end
         if (c == 2) bus.bus_req[2] = 1'b0;
         if (c == 4) set_req(1, 1'b0, 0);
      end
      n_cmp++;
      if (hist[2] !== 4'b0100 || tl_hist[2] !== 6'd8 || hist[3] !== 4'b0000 ||
          tl_hist[3] !== 6'd0) begin
         n_bad++;
         $display("FAIL early_release: got %b/%0d %b/%0d want 0100/8 0000/0",
                  hist[2], tl_hist[2], hist[3], tl_hist[3]);
      end
      n_cmp++;
      if (hist[5] !== 4'b0010 || tl_hist[5] !== 6'd1 || hist[6] !== 4'b0000) begin
         n_bad++;
         $display("FAIL clc_zero: got %b/%0d %b want 0010/1 0000",
                  hist[5], tl_hist[5], hist[6]);
      end
      drive_idle();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      set_req(1, 1'b0, 7);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      #1 rst = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (bus.bus_grant !== 4'b0000 || bus.bus_active !== 1'b0 || bus.tenure_left !== 6'd0) begin
         n_bad++;
         $display("FAIL rstmid_async: got grant %b active %b tl %0d want 0000 0 0",
                  bus.bus_grant, bus.bus_active, bus.tenure_left);
      end
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 3);
      @(posedge plusclk);
      @(negedge plusclk);
      rst = 1'b1;
      tick();
      n_cmp++;
      if (bus.bus_grant !== 4'b0001 || obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL rstmid_first: got %b (%h) want 0001 (%h)",
                  bus.bus_grant, obs_vec(), exp_vec());
      end
      drive_idle();
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!bus.bus_req[i]) begin
               if ($urandom_range(0, 99) < 30)
                  set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
            end else if (m_owner == i) begin
               if ($urandom_range(0, 99) < 10) bus.bus_req[i] = 1'b0;
            end else begin
               if ($urandom_range(0, 99) < 8) bus.bus_req[i] = 1'b0;
               else if ($urandom_range(0, 99) < 5)
                  bus.bus_req_type[i] = ~bus.bus_req_type[i];
            end
         end
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_single();
      test_round_robin();
      test_priority();
      test_starvation();
      test_early_release();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
